// File: rtl/muldiv_defs.sv
// Shared encodings for the HI/LO multiply/divide sequencer and a ceiling-log2 helper.
package muldiv_defs;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the 2W working register.
module muldiv_step
    import muldiv_defs::*;
#(
    parameter int W = 32
) (
    input  logic [2*W-1:0] i_work,
    input  logic [W-1:0]   i_operand,
    input  logic           i_is_div,
    output logic [2*W-1:0] o_work
);

    logic [W:0] upper_sum;
    logic [W:0] rem_shift;
    logic [W:0] trial;

    always_comb begin
        upper_sum = {1'b0, i_work[2*W-1:W]};
        rem_shift = i_work[2*W-1:W-1];
        trial     = rem_shift - {1'b0, i_operand};
        o_work    = i_work;
        if (i_is_div) begin
            // A clear borrow bit means the trial subtraction did not go negative.
            if (!trial[W]) begin
                o_work = {trial[W-1:0], i_work[W-2:0], 1'b1};
            end else begin
                o_work = {rem_shift[W-1:0], i_work[W-2:0], 1'b0};
            end
        end else begin
            if (i_work[0]) begin
                upper_sum = {1'b0, i_work[2*W-1:W]} + {1'b0, i_operand};
            end
            o_work = {upper_sum, i_work[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MTHI/MTLO write directly.
// Define MULDIV_EARLY_OUT_EN to let multiplies exit RUN once no multiplier bits remain.
module muldiv_seq
    import muldiv_defs::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_zero,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = log2(DATA_WIDTH);

    logic [1:0]     state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*W-1:0] work_q, work_d, step_work;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic           done_q, done_d, div_zero_q, div_zero_d;

    logic           op_is_div, op_signed, a_neg, b_neg, early_exit;
    logic [W-1:0]   mag_a, mag_b, quo, rem;
    logic [2*W-1:0] prod;

    assign op_is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
    assign op_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    assign a_neg     = op_signed & a_q[W-1];
    assign b_neg     = op_signed & b_q[W-1];
    assign mag_a     = a_neg ? -a_q : a_q;
    assign mag_b     = b_neg ? -b_q : b_q;

`ifdef MULDIV_EARLY_OUT_EN
    logic [W-1:0] mplier_q, mplier_d, mplier_rest;

    assign mplier_rest = mplier_q >> cnt_q;
    assign early_exit  = !op_is_div && (mplier_rest[W-1:1] == '0);
`else
    assign early_exit  = 1'b0;
`endif

    muldiv_step #(.W(W)) u_step (
        .i_work    (work_q),
        .i_operand (opnd_q),
        .i_is_div  (op_is_div),
        .o_work    (step_work)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        quo        = '0;
        rem        = '0;
        prod       = '0;
`ifdef MULDIV_EARLY_OUT_EN
        mplier_d   = mplier_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    case (i_op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            op_d    = i_op;
                            a_d     = i_data_a;
                            b_d     = i_data_b;
                            state_d = S_PREP;
                        end
                        MD_MTHI: hi_d = i_data_a;
                        MD_MTLO: lo_d = i_data_a;
                        default: ;
                    endcase
                end
            end
            S_PREP: begin
                opnd_d  = op_is_div ? mag_b : mag_a;
                work_d  = {{W{1'b0}}, (op_is_div ? mag_a : mag_b)};
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dz_d    = (b_q == '0);
                cnt_d   = '0;
`ifdef MULDIV_EARLY_OUT_EN
                mplier_d = mag_b;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
                work_d = step_work;
                // On an early exit the counter is held so FIX knows how many shifts remain.
                if ((cnt_q == CW'(W - 1)) || early_exit) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                if (op_is_div) begin
                    quo = neg_q  ? -work_q[W-1:0]   : work_q[W-1:0];
                    rem = rneg_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];
                    hi_d = dz_q ? a_q : rem;
                    lo_d = dz_q ? '1  : quo;
                end else begin
`ifdef MULDIV_EARLY_OUT_EN
                    prod = work_q >> (CW'(W - 1) - cnt_q);
`else
                    prod = work_q;
`endif
                    if (neg_q) begin
                        prod = -prod;
                    end
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end
                done_d     = 1'b1;
                div_zero_d = op_is_div & dz_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush cancels whatever this cycle would have done, including a FIX write or an MTHI/MTLO.
        if (i_flush) begin
            state_d    = S_IDLE;
            hi_d       = hi_q;
            lo_d       = lo_q;
            done_d     = 1'b0;
            div_zero_d = div_zero_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef MULDIV_EARLY_OUT_EN
            mplier_q   <= mplier_d;
`endif
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = done_q;
    assign o_div_zero = div_zero_q;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, hand-written corner sequences, random ops vs. an arithmetic model.
module tb_muldiv_seq;

    localparam int W = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic [2:0]    i_op = 3'b000;
    logic [W-1:0]  i_data_a = '0;
    logic [W-1:0]  i_data_b = '0;
    logic          i_flush = 1'b0;
    logic          o_busy, o_done, o_div_zero;
    logic [W-1:0]  o_hi, o_lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs[8];

    muldiv_seq #(.DATA_WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .i_flush    (i_flush),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero like MIPS.
    function automatic logic [2*W-1:0] ref_hilo(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            3'b000: p = sa * sb;
            3'b001: p = {32'b0, a} * {32'b0, b};
            3'b010: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] b);
        int idx;
        logic [W-1:0] mag;
        idx = 0;
        mag = b;
`ifdef MULDIV_EARLY_OUT_EN
        if (op == 3'b000 || op == 3'b001) begin
            if (op == 3'b000 && b[W-1]) mag = -b;
            for (int i = 0; i < W; i++) if (mag[i]) idx = i;
            return 3 + idx;
        end
`endif
        return W + 2 + idx + int'(mag[0] & 1'b0) + int'(op[2] & 1'b0);
    endfunction

    task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        i_start  = 1'b1;
        i_op     = op;
        i_data_a = a;
        i_data_b = b;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (o_done) seen = 1'b1;
        end
        check_output({name, " latency"}, W'(cyc), W'(exp_lat));
        check_output({name, " busy_at_done"}, {31'b0, o_busy}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz);
        apply_stimulus(op, a, b);
        check_output({name, " busy"}, {31'b0, o_busy}, 32'd1);
        wait_done(name, ref_latency(op, b));
        check_output({name, " hi"}, o_hi, exp_hi);
        check_output({name, " lo"}, o_lo, exp_lo);
        check_output({name, " div_zero"}, {31'b0, o_div_zero}, {31'b0, exp_dz});
    endtask

    initial begin
        logic [W-1:0] save_hi, save_lo, ra, rb;
        logic [2:0]   rop;
        logic [2*W-1:0] exp;
        int done_count;

        vecs[0] = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[1] = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0};
        vecs[2] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{3'b011, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{3'b001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[7] = '{3'b001, 32'h0000_1234, 32'h0000_0001, 32'h0000_0000, 32'h0000_1234, 1'b0};

        #2 i_rst_n = 1'b0;
        #10;
        check_output("reset busy", {31'b0, o_busy}, 32'd0);
        check_output("reset done", {31'b0, o_done}, 32'd0);
        check_output("reset div_zero", {31'b0, o_div_zero}, 32'd0);
        check_output("reset hi", o_hi, 32'd0);
        check_output("reset lo", o_lo, 32'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // MTHI then MTLO in consecutive idle cycles.
        @(posedge i_clk);
        #1;
        apply_stimulus(3'b100, 32'hAAAA_5555, 32'h0);
        check_output("mthi hi", o_hi, 32'hAAAA_5555);
        check_output("mthi busy", {31'b0, o_busy}, 32'd0);
        check_output("mthi done", {31'b0, o_done}, 32'd0);
        apply_stimulus(3'b101, 32'h5555_AAAA, 32'h0);
        check_output("mtlo lo", o_lo, 32'h5555_AAAA);
        check_output("mtlo hi", o_hi, 32'hAAAA_5555);
        check_output("mtlo busy", {31'b0, o_busy}, 32'd0);
        check_output("mtlo done", {31'b0, o_done}, 32'd0);

        apply_stimulus(3'b110, 32'h1111_1111, 32'h2);
        check_output("noop busy", {31'b0, o_busy}, 32'd0);
        check_output("noop hi", o_hi, 32'hAAAA_5555);
        check_output("noop lo", o_lo, 32'h5555_AAAA);

        i_flush = 1'b1;
        apply_stimulus(3'b100, 32'hDEAD_BEEF, 32'h0);
        i_flush = 1'b0;
        check_output("flushed mthi hi", o_hi, 32'hAAAA_5555);

        // A second start while busy must not disturb the first operation.
        apply_stimulus(3'b001, 32'd3, 32'd5);
        i_start = 1'b1; i_op = 3'b011; i_data_a = 32'd100; i_data_b = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
        end
        i_start = 1'b0;
        wait_done("busy_ignore", ref_latency(3'b001, 32'd5) - 3);
        check_output("busy_ignore hi", o_hi, 32'd0);
        check_output("busy_ignore lo", o_lo, 32'd15);
        @(posedge i_clk);
        #1;
        check_output("done pulse width", {31'b0, o_done}, 32'd0);
        check_output("no queued op", {31'b0, o_busy}, 32'd0);

        // Flush a MULTU in flight at cycle 10.
        save_hi = o_hi;
        save_lo = o_lo;
        apply_stimulus(3'b001, 32'h0000_FFFF, 32'h8000_0001);
        for (int i = 0; i < 9; i++) begin
            @(posedge i_clk);
            #1;
        end
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check_output("flush busy", {31'b0, o_busy}, 32'd0);
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_done) done_count++;
        end
        check_output("flush no done", W'(done_count), 32'd0);
        check_output("flush hi", o_hi, save_hi);
        check_output("flush lo", o_lo, save_lo);

        // Random back-to-back ops against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: ra = 32'h8000_0000;
                3: rb = W'($urandom_range(0, 15));
                default: ;
            endcase
            exp = ref_hilo(rop, ra, rb);
            run_op($sformatf("rand%0d op%0d a=%h b=%h", n, rop, ra, rb), rop, ra, rb,
                   exp[2*W-1:W], exp[W-1:0], rop[1] && (rb == '0));
        end

        // Async reset in the middle of a DIV clears everything immediately.
        apply_stimulus(3'b100, 32'h0BAD_F00D, 32'h0);
        apply_stimulus(3'b010, 32'd1000, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1;
        end
        #2 i_rst_n = 1'b0;
        #1;
        check_output("midreset busy", {31'b0, o_busy}, 32'd0);
        check_output("midreset done", {31'b0, o_done}, 32'd0);
        check_output("midreset div_zero", {31'b0, o_div_zero}, 32'd0);
        check_output("midreset hi", o_hi, 32'd0);
        check_output("midreset lo", o_lo, 32'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
